// File: rtl/aqp_uart_rx_fifo_if.sv
// Host-side read bus of the UART receiver FIFO: show-ahead head entry, pop, occupancy and overflow.
// master = receiver (drives head/status), slave = host (drives rd_ack / overflow_clr).
interface aqp_uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_perr;
  logic                 rd_ferr;
  logic                 rd_valid;
  logic                 rd_ack;
  logic [CW-1:0]        fifo_count;
  logic                 overflow;
  logic                 overflow_clr;

  modport master (
    output rd_data, rd_perr, rd_ferr, rd_valid, fifo_count, overflow,
    input  rd_ack, overflow_clr
  );

  modport slave (
    input  rd_data, rd_perr, rd_ferr, rd_valid, fifo_count, overflow,
    output rd_ack, overflow_clr
  );
endinterface

// File: rtl/aqp_uart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead FIFO with per-entry parity/framing flags.
// Optional parity checking is compiled in with the macro AQP_UART_RX_PARITY_EN.
module aqp_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  aqp_uart_rx_fifo_if.master   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
`ifdef AQP_UART_RX_PARITY_EN
  localparam int WW = DATA_BITS + 2;
`else
  localparam int WW = DATA_BITS + 1;
`endif
  localparam logic [BW-1:0] SAMPLE_PT = BW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] LAST_CNT  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef AQP_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic sync_p0, sync_p1, sync_p2, sync_p3;
  logic rx_in, fall, sample;

  state_t                state;
  logic [BW-1:0]         bit_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_BITS-1:0]  shreg;

  logic                  push, pop, full, wr_en, ovf_set;
  logic [WW-1:0]         push_word, head_word;
  logic [WW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow_r;

`ifdef AQP_UART_RX_PARITY_EN
  logic perr, par_en_r, par_odd_r;
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd;
`endif

  // stage p0..p2: metastability chain; p3 only exists for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sync_p3, sync_p2, sync_p1, sync_p0} <= 4'b1111;
    end else begin
      sync_p0 <= uart_rxd;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      sync_p3 <= sync_p2;
    end
  end

  assign rx_in  = sync_p2;
  assign fall   = sync_p3 & ~sync_p2;
  assign sample = (bit_cnt == SAMPLE_PT);

  // frame FSM: bit_cnt free-runs and is only re-phased when a start edge is seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
`ifdef AQP_UART_RX_PARITY_EN
      perr      <= 1'b0;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
`endif
    end else begin
      bit_cnt <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (fall) begin
            state   <= S_START;
            bit_cnt <= '0;
          end
        end
        S_START: begin
          if (sample) begin
            if (rx_in) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
`ifdef AQP_UART_RX_PARITY_EN
              perr      <= 1'b0;
              par_en_r  <= parity_en;
              par_odd_r <= parity_odd;
`endif
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
`ifdef AQP_UART_RX_PARITY_EN
              state <= par_en_r ? S_PARITY : S_STOP;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef AQP_UART_RX_PARITY_EN
        S_PARITY: begin
          if (sample) begin
            perr  <= (((^shreg) ^ rx_in) != par_odd_r);
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (sample) state <= rx_in ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (rx_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // data shift register carries no reset; the FSM guarantees it is refilled before use
  always_ff @(posedge clk) begin
    if (state == S_DATA && sample) shreg <= {rx_in, shreg[DATA_BITS-1:1]};
  end

  assign push = (state == S_STOP) && sample;
`ifdef AQP_UART_RX_PARITY_EN
  assign push_word = {perr, ~rx_in, shreg};
`else
  assign push_word = {~rx_in, shreg};
`endif

  assign pop     = bus.rd_ack & bus.rd_valid;
  assign full    = (count == FULL_CNT);
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_word;
  end

  // FIFO control: a push into a full FIFO survives only if the head is popped in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
      if (ovf_set)               overflow_r <= 1'b1;
      else if (bus.overflow_clr) overflow_r <= 1'b0;
    end
  end

  assign head_word      = mem[rd_ptr];
  assign bus.rd_valid   = (count != '0);
  assign bus.rd_data    = bus.rd_valid ? head_word[DATA_BITS-1:0] : '0;
  assign bus.rd_ferr    = bus.rd_valid & head_word[DATA_BITS];
`ifdef AQP_UART_RX_PARITY_EN
  assign bus.rd_perr    = bus.rd_valid & head_word[DATA_BITS+1];
`else
  assign bus.rd_perr    = 1'b0;
`endif
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_aqp_uart_rx_fifo.sv
// Directed + randomized bench for aqp_uart_rx_fifo; frames are driven serially and
// checked against a queue model of what each frame should leave in the FIFO.
module tb_aqp_uart_rx_fifo;
  localparam int CPB   = 8;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
`ifdef AQP_UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, uart_rxd, parity_en, parity_odd;

  always #5 clk = ~clk;

  aqp_uart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();

  aqp_uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .bus       (bus)
  );

  // model entry layout: {perr, ferr, data}
  logic [DB+1:0] model_q[$];
  bit            model_ovf;
  int            n_asrt = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // What the receiver should make of a frame, from the serial bit list alone
  task automatic model_frame(input logic [DB-1:0] d, input bit has_par, input bit pbit, input bit stop);
    bit            chk_par;
    bit            stop_slot;
    bit            perr;
    chk_par   = PAR_BUILD && parity_en;
    stop_slot = (has_par && !chk_par) ? pbit : stop;
    perr      = chk_par && ((($countones(d) + int'(pbit)) % 2) != int'(parity_odd));
    if (model_q.size() < DEPTH) model_q.push_back({perr, ~stop_slot, d});
    else model_ovf = 1'b1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit has_par, input bit pbit,
                            input bit stop, input int stop_len);
    model_frame(d, has_par, pbit, stop);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      uart_rxd = d[i];
      tick(CPB);
    end
    if (has_par) begin
      uart_rxd = pbit;
      tick(CPB);
    end
    uart_rxd = stop;
    tick(stop_len);
    uart_rxd = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".count"}, 32'(bus.fifo_count), 32'(model_q.size()));
    chk({tag, ".valid"}, 32'(bus.rd_valid), 32'(model_q.size() != 0));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(model_ovf));
  endtask

  task automatic pop_check(input string tag);
    logic [DB+1:0] e;
    if (model_q.size() == 0) begin
      chk({tag, ".valid"}, 32'(bus.rd_valid), 32'd0);
    end else begin
      e = model_q.pop_front();
      chk({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
      chk({tag, ".data"}, 32'(bus.rd_data), 32'(e[DB-1:0]));
      chk({tag, ".ferr"}, 32'(bus.rd_ferr), 32'(e[DB]));
      chk({tag, ".perr"}, 32'(bus.rd_perr), 32'(e[DB+1]));
      bus.rd_ack = 1'b1;
      tick(1);
      bus.rd_ack = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DB-1:0] d;
    bit pb, st, hp;
    reset = 1'b1; uart_rxd = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    bus.rd_ack = 1'b0; bus.overflow_clr = 1'b0;
    model_ovf = 1'b0;
    tick(3);
    chk("rst.count", 32'(bus.fifo_count), 32'd0);
    chk("rst.valid", 32'(bus.rd_valid), 32'd0);
    chk("rst.data", 32'(bus.rd_data), 32'd0);
    chk("rst.flags", 32'({bus.rd_perr, bus.rd_ferr, bus.overflow}), 32'd0);
    reset = 1'b0;
    tick(2);

    // single clean character, then pop
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, CPB);
    check_status("a5");
    pop_check("a5.pop");
    check_status("a5.empty");

    // short low glitch must be rejected as a false start
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(3 * CPB);
    check_status("glitch");

    // stop bit held low: framing error, then no pushes until the line recovers
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 40);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, CPB);
    check_status("brk");
    pop_check("brk.3c");
    pop_check("brk.55");

    // overflow on the fifth character
    for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b0, 1'b0, 1'b1, CPB);
    check_status("ovf");
    for (int i = 0; i < DEPTH; i++) pop_check("ovf.pop");
    check_status("ovf.drained");
    bus.overflow_clr = 1'b1;
    tick(1);
    bus.overflow_clr = 1'b0;
    model_ovf = 1'b0;
    check_status("ovf.clr");

    // even parity, correct and incorrect parity bit
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, CPB);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, CPB);
    check_status("par");
    pop_check("par.ok");
    pop_check("par.bad");

    // randomized frames, parity settings and pops
    for (int n = 0; n < 12; n++) begin
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      d  = DB'($urandom);
      hp = parity_en;
      pb = 1'($urandom_range(0, 1));
      st = hp ? 1'b1 : ($urandom_range(0, 4) != 0);
      send_frame(d, hp, pb, st, CPB);
      check_status("rnd");
      for (int k = $urandom_range(0, 2); k > 0; k--) pop_check("rnd.pop");
    end
    while (model_q.size() != 0) pop_check("rnd.drain");
    check_status("rnd.end");
    bus.overflow_clr = 1'b1;
    tick(1);
    bus.overflow_clr = 1'b0;
    model_ovf = 1'b0;

    // reset in the middle of the data bits with one entry already queued
    parity_en = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, CPB);
    check_status("pre_rst");
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = 1'(i & 1);
      tick(CPB);
    end
    reset = 1'b1;
    uart_rxd = 1'b1;
    tick(2);
    model_q.delete();
    chk("mrst.count", 32'(bus.fifo_count), 32'd0);
    chk("mrst.outs", 32'({bus.rd_data, bus.rd_perr, bus.rd_ferr, bus.rd_valid, bus.overflow}), 32'd0);
    reset = 1'b0;
    tick(2 * CPB);
    check_status("mrst.idle");
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, CPB);
    check_status("mrst.81");
    pop_check("mrst.81.pop");
    check_status("mrst.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/aqp_uart_rx_fifo.md
Name: aqp_uart_rx_fifo

Overview:
- Parametrised next-generation UART receiver for the ESP link.
- Oversample ratio, data width and FIFO depth are configurable; optional parity checking is available.
- Received characters go into a show-ahead FIFO with per-entry error flags, so the host bus does not lose bytes while it is busy.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per bit; minimum 4, even values only.
- DATA_BITS, 8, data bits per frame; range 5..9; sent LSB first.
- FIFO_DEPTH, 16, number of FIFO entries; power of 2; range 2..256.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- uart_rxd  in  1  serial line, asynchronous to clk, idles high.
- parity_en  in  1  1 = frame carries a parity bit (used only with the optional feature).
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- rd_data  out  DATA_BITS  data at the FIFO head.
- rd_perr  out  1  parity error flag of the head entry.
- rd_ferr  out  1  framing error flag of the head entry.
- rd_valid  out  1  FIFO is not empty.
- rd_ack  in  1  pops the head entry when rd_valid=1; ignored when rd_valid=0.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag: a character was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, the FSM is in IDLE, and the synchroniser is loaded with 1s.
- Input sync: 3-flop synchroniser; rx_in is the 3rd stage; a falling edge is 4th stage 1 and 3rd stage 0.
- bit_cnt runs 0..CLKS_PER_BIT-1 and wraps; it is cleared on entry to START. The sample point is bit_cnt == CLKS_PER_BIT/2.
- IDLE: a falling edge moves to START.
- START: at the sample point, rx_in=1 means a false start: return to IDLE, push nothing. rx_in=0 moves to DATA.
- DATA: sample DATA_BITS bits, shifting right so the first bit received ends up in the LSB. After the last bit, go to PARITY if the feature is compiled in and parity_en=1; otherwise go to STOP.
- PARITY: at the sample point, perr = (XOR of data bits XOR received parity bit) != parity_odd. Then go to STOP.
- STOP: at the sample point, push {perr, ferr = ~rx_in, data}.
  - rx_in=1: go to IDLE in the same cycle, which allows back-to-back frames.
  - rx_in=0: go to BREAK.
- BREAK: wait until rx_in=1, then go to IDLE. No further pushes occur while in BREAK.
- parity_en and parity_odd are sampled on the START-to-DATA transition; changing them mid-frame has no effect on that frame.
- Latency: rd_valid rises 1 cycle after the stop-sample cycle when the FIFO was empty.
- FIFO: show-ahead; the rd_* outputs are registered or RAM-read with the head always presented.
  - Pop occurs when rd_ack & rd_valid.
  - Push while full and with no pop in the same cycle: the character is dropped and overflow is set.
  - Push and pop in the same cycle while full: both are accepted; count stays at FIFO_DEPTH; no overflow.
  - Push and pop in the same cycle while non-empty: count is unchanged.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- overflow: setting wins over overflow_clr in the same cycle.
- Reset mid-frame: the FSM aborts to IDLE, the FIFO is emptied, and no partial frame is pushed.

Optional Feature:
- Macro: AQP_UART_RX_PARITY_EN.
- Defined: the PARITY state exists and parity_en / parity_odd are honoured as described above.
- Not defined: the PARITY state is omitted; parity_en and parity_odd are ignored; rd_perr is tied to 0. DATA always proceeds directly to STOP.

Test Plan:
- CLKS_PER_BIT=8, DATA_BITS=8: send 0xA5 with 1 stop bit -> rd_valid=1, rd_data=0xA5, rd_perr=0, rd_ferr=0, fifo_count=1; rd_ack -> fifo_count=0, rd_valid=0.
- Low glitch of 3 clk on the idle line -> false start, no push, fifo_count stays 0.
- Send 0x3C with stop bit held 0 for 40 clk, then line high, then send 0x55 -> entries {ferr=1, 0x3C} then {ferr=0, 0x55}; no extra entries pushed while in BREAK.
- FIFO_DEPTH=4: send 5 characters 0x01..0x05 without rd_ack -> fifo_count=4, overflow=1, head=0x01; pop all -> 0x01..0x04; overflow_clr -> overflow=0.
- With AQP_UART_RX_PARITY_EN, parity_en=1, parity_odd=0: send 0x07 with parity bit 1 -> perr=0; send 0x07 with parity bit 0 -> perr=1. Repeat with the macro undefined -> the parity bit slot is taken as the stop bit, and perr is always 0.
- Assert reset midway through the DATA bits of a frame -> FIFO empty, all outputs 0; the next complete frame 0x81 is received correctly.
